// File: rtl/voice_amp_sequencer_if.sv
// rtl/voice_amp_sequencer_if.sv - shared 8x8 multiplier operand/product bus
interface voice_amp_sequencer_if;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_p;

  // The sequencer drives the operands and reads back the product
  modport master (output mul_a, output mul_b, input mul_p);
  // The external multiplier returns mul_a*mul_b combinationally
  modport slave  (input mul_a, input mul_b, output mul_p);
endinterface

// File: rtl/voice_amp_sequencer.sv
// rtl/voice_amp_sequencer.sv - time-multiplexed voice amplitude scaler and saturating mixer
module voice_amp_sequencer #(
  parameter int N_VOICES = 4,
  parameter int VW       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic [8*N_VOICES-1:0] wave_in,
  input  logic [8*N_VOICES-1:0] env_in,
  input  logic [N_VOICES-1:0]   voice_en,
  input  logic [7:0]            master_amplitude,
  voice_amp_sequencer_if.master mul,
  output logic [7:0]            sample_out,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic [1:0] {IDLE, ENV, MST, DONE} state_t;

  localparam int            AW     = 8 + VW;
  localparam logic [VW-1:0] V_LAST = VW'(N_VOICES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [VW-1:0] v;
  logic [VW-1:0] v_nxt;
  logic [7:0]    mst_q;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_sum;
  logic [7:0]    a_nxt;
  logic [7:0]    b_nxt;
  logic [7:0]    prod_hi;
  logic [7:0]    sat;
  logic [7:0]    wave_v [N_VOICES];
  logic [7:0]    env_v  [N_VOICES];
  logic          unused_prod_lo;

  // Split the flat per-voice buses into byte lanes indexed by voice
  for (genvar g = 0; g < N_VOICES; g++) begin : g_lane
    assign wave_v[g] = wave_in[8*g +: 8];
    assign env_v[g]  = env_in[8*g +: 8];
  end

  // Every scaling stage keeps only the upper byte of the product
  assign prod_hi        = mul.mul_p[15:8];
  assign unused_prod_lo = ^mul.mul_p[7:0];

  // Running mix including the current MST slot; disabled voices add nothing
  assign acc_sum = acc + (voice_en[v] ? AW'(prod_hi) : AW'(0));
  assign sat     = (acc_sum > AW'(255)) ? 8'hFF : acc_sum[7:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: two multiplier slots per voice, then one DONE cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_tick) state_nxt = ENV;
      ENV:     state_nxt = MST;
      MST:     state_nxt = (v == V_LAST) ? DONE : ENV;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: next voice index and the operands for the upcoming slot
  always_comb begin
    v_nxt = v;
    a_nxt = '0;
    b_nxt = '0;
    busy  = (state != IDLE);
    if (state == IDLE) begin
      v_nxt = '0;
    end else if ((state == MST) && (v != V_LAST)) begin
      v_nxt = v + 1'b1;
    end
    case (state_nxt)
      ENV: begin
        a_nxt = wave_v[v_nxt];
        b_nxt = env_v[v_nxt];
      end
      // The ENV result goes straight into mul_a, so it doubles as the tmp stage
      MST: begin
        a_nxt = prod_hi;
        b_nxt = mst_q;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers: operands, voice index, master latch, accumulator, outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul.mul_a    <= '0;
      mul.mul_b    <= '0;
      v            <= '0;
      mst_q        <= '0;
      acc          <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      mul.mul_a    <= a_nxt;
      mul.mul_b    <= b_nxt;
      v            <= v_nxt;
      sample_valid <= (state_nxt == DONE);
      overrun      <= sample_tick && (state != IDLE);
      if ((state == IDLE) && sample_tick) begin
        mst_q <= master_amplitude;
        acc   <= '0;
      end
      if (state == MST) begin
        acc <= acc_sum;
      end
      // Load the sample on entry to DONE so it is stable while sample_valid is high
      if ((state == MST) && (v == V_LAST)) begin
        sample_out <= sat;
      end
    end
  end

endmodule

// File: tb/tb_voice_amp_sequencer.sv
// tb/tb_voice_amp_sequencer.sv - scoreboard bench for voice_amp_sequencer
module tb_voice_amp_sequencer;
  localparam int N = 4;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           sample_tick = 1'b0;
  logic [8*N-1:0] wave_in = '0;
  logic [8*N-1:0] env_in = '0;
  logic [N-1:0]   voice_en = '0;
  logic [7:0]     master_amplitude = '0;
  logic [7:0]     sample_out;
  logic           sample_valid;
  logic           busy;
  logic           overrun;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   next_accept = 0;
  int   acc_cyc = -100;
  exp_t sq[$];
  int   oq[$];

  logic exp_v;
  logic exp_o;
  logic exp_b;
  exp_t e;

  voice_amp_sequencer_if bus ();

  // Ideal combinational multiplier on the shared bus
  assign bus.mul_p = {8'h00, bus.mul_a} * {8'h00, bus.mul_b};

  voice_amp_sequencer #(.N_VOICES(N), .VW(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sample_tick      (sample_tick),
    .wave_in          (wave_in),
    .env_in           (env_in),
    .voice_en         (voice_en),
    .master_amplitude (master_amplitude),
    .mul              (bus),
    .sample_out       (sample_out),
    .sample_valid     (sample_valid),
    .busy             (busy),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_sample();
    logic [9:0]  sum;
    logic [15:0] t;
    logic [15:0] p;
    sum = '0;
    for (int vi = 0; vi < N; vi++) begin
      t = {8'h00, wave_in[8*vi +: 8]} * {8'h00, env_in[8*vi +: 8]};
      p = {8'h00, t[15:8]} * {8'h00, master_amplitude};
      if (voice_en[vi]) sum = sum + {2'b00, p[15:8]};
    end
    return (sum > 10'd255) ? 8'hFF : sum[7:0];
  endfunction

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a one-cycle tick in the current cycle and record what it must cause
  task automatic pulse_tick();
    exp_t x;
    if (cyc < next_accept) begin
      oq.push_back(cyc + 1);
    end else begin
      x.cyc = cyc + 2*N + 1;
      x.val = model_sample();
      sq.push_back(x);
      acc_cyc     = cyc;
      next_accept = cyc + 2*N + 2;
    end
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
  endtask

  task automatic frame();
    int c0;
    c0 = cyc;
    pulse_tick();
    wait_to(c0 + 2*N + 2);
  endtask

  task automatic set_all(input logic [7:0] w, input logic [7:0] en, input logic [N-1:0] ven,
                         input logic [7:0] m);
    for (int vi = 0; vi < N; vi++) begin
      wave_in[8*vi +: 8] = w;
      env_in[8*vi +: 8]  = en;
    end
    voice_en         = ven;
    master_amplitude = m;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_sample_out"}, sample_out, 0);
    check_eq({tag, "_valid"}, sample_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_overrun"}, overrun, 0);
    check_eq({tag, "_mul_a"}, bus.mul_a, 0);
    check_eq({tag, "_mul_b"}, bus.mul_b, 0);
  endtask

  // Cycle monitor: valid/overrun/busy timing against the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      exp_v = (sq.size() > 0) && (sq[0].cyc == cyc);
      check_eq("sample_valid", sample_valid, exp_v);
      if (exp_v) begin
        e = sq.pop_front();
        check_eq("sample_out", sample_out, e.val);
      end
      exp_o = (oq.size() > 0) && (oq[0] == cyc);
      check_eq("overrun", overrun, exp_o);
      if (exp_o) void'(oq.pop_front());
      exp_b = (cyc > acc_cyc) && (cyc <= acc_cyc + 2*N + 1);
      check_eq("busy", busy, exp_b);
      if (!exp_b) begin
        check_eq("idle_mul_a", bus.mul_a, 0);
        check_eq("idle_mul_b", bus.mul_b, 0);
      end
    end
  end

  initial begin
    int c0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One voice, half scale twice, full master: 0x80*0x80 -> 0x40, *0xFF -> 0x3F
    set_all(8'h80, 8'h80, 4'b0001, 8'hFF);
    frame();
    check_eq("t_single", sample_out, 8'h3F);

    // All voices full scale: 0xFD each, 0x3F4 total saturates
    set_all(8'hFF, 8'hFF, 4'b1111, 8'hFF);
    frame();
    check_eq("t_saturate", sample_out, 8'hFF);

    set_all(8'hFF, 8'hFF, 4'b0000, 8'hFF);
    frame();
    check_eq("t_none_en", sample_out, 8'h00);

    set_all(8'hFF, 8'hFF, 4'b1111, 8'hFF);
    frame();
    set_all(8'hFF, 8'hFF, 4'b1111, 8'h00);
    frame();
    check_eq("t_master0", sample_out, 8'h00);

    // Ticks at 0, 4 and 9 drop two; a tick at 10 starts a new frame
    set_all(8'h40, 8'hC0, 4'b0110, 8'h90);
    c0 = cyc;
    pulse_tick();
    wait_to(c0 + 4);
    pulse_tick();
    wait_to(c0 + 9);
    pulse_tick();
    pulse_tick();
    wait_to(c0 + 20);

    // Master changes mid-frame: the frame uses the value latched at the tick
    set_all(8'hFF, 8'hFF, 4'b0001, 8'hFF);
    c0 = cyc;
    pulse_tick();
    wait_to(c0 + 3);
    master_amplitude = 8'h00;
    wait_to(c0 + 10);
    check_eq("t_master_latch", sample_out, 8'hFD);
    frame();
    check_eq("t_master_next", sample_out, 8'h00);

    // Reset in the middle of a frame, then a clean frame
    set_all(8'hFF, 8'hFF, 4'b1111, 8'hFF);
    c0 = cyc;
    pulse_tick();
    wait_to(c0 + 4);
    rst_n = 1'b0;
    sq.delete();
    oq.delete();
    acc_cyc     = -100;
    next_accept = 0;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_all(8'h80, 8'h80, 4'b0001, 8'hFF);
    frame();
    check_eq("t_after_reset", sample_out, 8'h3F);

    // Random frames checked against the model
    for (int k = 0; k < 8; k++) begin
      wave_in          = $urandom;
      env_in           = $urandom;
      voice_en         = 4'($urandom_range(0, 15));
      master_amplitude = 8'($urandom_range(0, 255));
      frame();
    end

    repeat (12) @(posedge clk);
    #1;
    check_eq("sq_drained", sq.size(), 0);
    check_eq("oq_drained", oq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
